// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//
// Selects forwarded operands, runs a single-cycle ALU or a 32-cycle
// shift-and-add multiplier, and owns the EX/MEM pipeline register.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   valid_i               ID/EX holds a real instruction
//   RsData_i, RtData_i    register operands from ID/EX
//   Imm_i                 sign-extended immediate
//   ALUSrc_i              1 = operand B is Imm_i
//   ALUCtrl_i             000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL,
//                         anything else ADD
//   WB_i, M_i             WB / MEM control carried to EX/MEM
//   WriteAddr_i           destination register
//   mux6_i, mux7_i        Rs / Rt forward select: 10 EX/MEM, 01 MEM/WB, else reg
//   EXMEM_Data_i          EX/MEM result for forwarding
//   MEMWB_Data_i          MEM/WB write-back data for forwarding
//   stall_o               hold PC, IF/ID and ID/EX this cycle
//   EXMEM_*_o             EX/MEM pipeline register contents
//   dbg_state_o           multiplier FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: there is no valid/ready pair here; stall_o is the only
// back-pressure. Upstream holds ID/EX steady in every cycle stall_o is 1 and
// advances on the first edge where it is 0.
module ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] RsData_i,
  input  logic [31:0] RtData_i,
  input  logic [31:0] Imm_i,
  input  logic        ALUSrc_i,
  input  logic [2:0]  ALUCtrl_i,
  input  logic [1:0]  WB_i,
  input  logic [1:0]  M_i,
  input  logic [4:0]  WriteAddr_i,
  input  logic [1:0]  mux6_i,
  input  logic [1:0]  mux7_i,
  input  logic [31:0] EXMEM_Data_i,
  input  logic [31:0] MEMWB_Data_i,
  output logic        stall_o,
  output logic [1:0]  EXMEM_WB_o,
  output logic [1:0]  EXMEM_M_o,
  output logic [31:0] EXMEM_ALUResult_o,
  output logic [31:0] EXMEM_RtData_o,
  output logic [4:0]  EXMEM_WriteAddr_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] op_a, rt_fwd, op_b, alu_res;
  logic [31:0] mcand, mplier, acc;
  logic [4:0]  cnt;
  logic        is_mul, mul_issue;

  // Operand selection (forwarding, then immediate mux for B).
  always_comb begin
    case (mux6_i)
      2'b10:   op_a = EXMEM_Data_i;
      2'b01:   op_a = MEMWB_Data_i;
      default: op_a = RsData_i;
    endcase
    case (mux7_i)
      2'b10:   rt_fwd = EXMEM_Data_i;
      2'b01:   rt_fwd = MEMWB_Data_i;
      default: rt_fwd = RtData_i;
    endcase
    op_b = ALUSrc_i ? Imm_i : rt_fwd;
  end

  // Single-cycle ALU; unknown codes fall through to ADD.
  always_comb begin
    case (ALUCtrl_i)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      default: alu_res = op_a + op_b;
    endcase
  end

  assign is_mul      = (ALUCtrl_i == OP_MUL);
  assign dbg_state_o = state;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next state and stall. A MUL still held in ID/EX during DONE must not
  // re-issue, which is why issue is only decoded in IDLE.
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    mul_issue  = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_i && is_mul) begin
          mul_issue  = 1'b1;
          stall_o    = 1'b1;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (cnt == 5'd31) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Shift-and-add multiplier. Operands are captured at issue so forwarding
  // sources may change freely while the downstream pipeline drains.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      cnt    <= 5'd0;
    end else if (mul_issue) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= 32'd0;
      cnt    <= 5'd0;
    end else if (state == S_BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
    end
  end

  // EX/MEM pipeline register. Everything that is not a completed result is
  // a bubble (all fields zero).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      EXMEM_WB_o        <= 2'b00;
      EXMEM_M_o         <= 2'b00;
      EXMEM_ALUResult_o <= 32'd0;
      EXMEM_RtData_o    <= 32'd0;
      EXMEM_WriteAddr_o <= 5'd0;
    end else if ((state == S_IDLE && valid_i && !is_mul) || state == S_DONE) begin
      EXMEM_WB_o        <= WB_i;
      EXMEM_M_o         <= M_i;
      EXMEM_ALUResult_o <= (state == S_DONE) ? acc : alu_res;
      EXMEM_RtData_o    <= rt_fwd;
      EXMEM_WriteAddr_o <= WriteAddr_i;
    end else begin
      EXMEM_WB_o        <= 2'b00;
      EXMEM_M_o         <= 2'b00;
      EXMEM_ALUResult_o <= 32'd0;
      EXMEM_RtData_o    <= 32'd0;
      EXMEM_WriteAddr_o <= 5'd0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against a
// behavioural model of the execute stage.
module tb_ex_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic        valid_i, ALUSrc_i;
  logic [31:0] RsData_i, RtData_i, Imm_i, EXMEM_Data_i, MEMWB_Data_i;
  logic [2:0]  ALUCtrl_i;
  logic [1:0]  WB_i, M_i, mux6_i, mux7_i;
  logic [4:0]  WriteAddr_i;
  logic        stall_o;
  logic [1:0]  EXMEM_WB_o, EXMEM_M_o, dbg_state_o;
  logic [31:0] EXMEM_ALUResult_o, EXMEM_RtData_o;
  logic [4:0]  EXMEM_WriteAddr_o;

  ex_stage dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i),
    .RsData_i(RsData_i), .RtData_i(RtData_i), .Imm_i(Imm_i),
    .ALUSrc_i(ALUSrc_i), .ALUCtrl_i(ALUCtrl_i), .WB_i(WB_i), .M_i(M_i),
    .WriteAddr_i(WriteAddr_i), .mux6_i(mux6_i), .mux7_i(mux7_i),
    .EXMEM_Data_i(EXMEM_Data_i), .MEMWB_Data_i(MEMWB_Data_i),
    .stall_o(stall_o), .EXMEM_WB_o(EXMEM_WB_o), .EXMEM_M_o(EXMEM_M_o),
    .EXMEM_ALUResult_o(EXMEM_ALUResult_o), .EXMEM_RtData_o(EXMEM_RtData_o),
    .EXMEM_WriteAddr_o(EXMEM_WriteAddr_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] ex, input logic [31:0] mw);
    if (sel == 2'b10) return ex;
    if (sel == 2'b01) return mw;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] ctrl);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctrl)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b110:  return 32'(longint'(a) - longint'(b));
      3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
      3'b011:  return 32'(longint'(a) * longint'(b));
      default: return 32'(longint'(a) + longint'(b));
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [2:0] ctrl, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm, input logic src,
                        input logic [1:0] m6, input logic [1:0] m7,
                        input logic [31:0] exd, input logic [31:0] mwd,
                        input logic [1:0] wb, input logic [1:0] m, input logic [4:0] wa);
    valid_i = v; ALUCtrl_i = ctrl; RsData_i = rs; RtData_i = rt; Imm_i = imm;
    ALUSrc_i = src; mux6_i = m6; mux7_i = m7; EXMEM_Data_i = exd;
    MEMWB_Data_i = mwd; WB_i = wb; M_i = m; WriteAddr_i = wa;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_res"}, EXMEM_ALUResult_o, 32'd0);
    check({tag, "_rt"},  EXMEM_RtData_o, 32'd0);
    check({tag, "_wa"},  32'(EXMEM_WriteAddr_o), 32'd0);
    check({tag, "_wb"},  32'(EXMEM_WB_o), 32'd0);
    check({tag, "_m"},   32'(EXMEM_M_o), 32'd0);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
  endtask

  // One single-cycle op (or a bubble when valid_i is 0).
  task automatic run_single(input string tag);
    logic [31:0] a, rtf, b, e_rt;
    logic [4:0]  e_wa;
    logic [1:0]  e_wb, e_m;
    a   = fwd_val(mux6_i, RsData_i, EXMEM_Data_i, MEMWB_Data_i);
    rtf = fwd_val(mux7_i, RtData_i, EXMEM_Data_i, MEMWB_Data_i);
    b   = ALUSrc_i ? Imm_i : rtf;
    if (valid_i) begin
      exp_q.push_back(alu_ref(a, b, ALUCtrl_i));
      e_rt = rtf; e_wa = WriteAddr_i; e_wb = WB_i; e_m = M_i;
    end else begin
      exp_q.push_back(32'd0);
      e_rt = 32'd0; e_wa = 5'd0; e_wb = 2'd0; e_m = 2'd0;
    end
    #1;
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    step();
    check({tag, "_res"}, EXMEM_ALUResult_o, exp_q.pop_front());
    check({tag, "_rt"},  EXMEM_RtData_o, e_rt);
    check({tag, "_wa"},  32'(EXMEM_WriteAddr_o), 32'(e_wa));
    check({tag, "_wb"},  32'(EXMEM_WB_o), 32'(e_wb));
    check({tag, "_m"},   32'(EXMEM_M_o), 32'(e_m));
  endtask

  // One MUL from issue to result; optionally scrambles forwarding sources
  // while busy (the product must not change).
  task automatic run_mul(input string tag, input bit perturb);
    logic [31:0] a, b, rtf;
    int stall_cnt;
    stall_cnt = 0;
    a = fwd_val(mux6_i, RsData_i, EXMEM_Data_i, MEMWB_Data_i);
    b = ALUSrc_i ? Imm_i : fwd_val(mux7_i, RtData_i, EXMEM_Data_i, MEMWB_Data_i);
    exp_q.push_back(alu_ref(a, b, 3'b011));
    #1;
    if (stall_o) stall_cnt++;
    step();
    for (int i = 0; i < 32; i++) begin
      if (stall_o) stall_cnt++;
      check({tag, "_bubble_wb"}, 32'(EXMEM_WB_o), 32'd0);
      if (perturb) begin
        EXMEM_Data_i = 32'd100 + $urandom_range(0, 1000);
        MEMWB_Data_i = $urandom;
      end
      step();
    end
    // DONE cycle: upstream may advance, store data is sampled now.
    check({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_done_wb"}, 32'(EXMEM_WB_o), 32'd0);
    rtf = fwd_val(mux7_i, RtData_i, EXMEM_Data_i, MEMWB_Data_i);
    step();
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd33);
    check({tag, "_res"}, EXMEM_ALUResult_o, exp_q.pop_front());
    check({tag, "_rt"},  EXMEM_RtData_o, rtf);
    check({tag, "_wa"},  32'(EXMEM_WriteAddr_o), 32'(WriteAddr_i));
    check({tag, "_wb"},  32'(EXMEM_WB_o), 32'(WB_i));
    check({tag, "_m"},   32'(EXMEM_M_o), 32'(M_i));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b0;
    set_op(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00,
           32'd0, 32'd0, 2'b00, 2'b00, 5'd0);
    #2;
    check_zero("reset");
    check("reset_state", 32'(dbg_state_o), 32'd0);
    #20 rst_i = 1'b1;
    step();

    // ADD with Rs forwarded from EX/MEM.
    set_op(1'b1, 3'b010, 32'd0, 32'd3, 32'd0, 1'b0, 2'b10, 2'b00,
           32'd5, 32'd0, 2'b10, 2'b01, 5'd9);
    run_single("add_fwd");
    check("add_fwd_const", EXMEM_ALUResult_o, 32'd8);

    // SLT / SUB with Rt forwarded from MEM/WB.
    set_op(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 2'b00, 2'b01,
           32'd0, 32'd1, 2'b10, 2'b00, 5'd4);
    run_single("slt");
    check("slt_const", EXMEM_ALUResult_o, 32'd1);
    ALUCtrl_i = 3'b110;
    run_single("sub");
    check("sub_const", EXMEM_ALUResult_o, 32'hFFFF_FFFE);

    // Asynchronous reset in the middle of a run.
    #2 rst_i = 1'b0; valid_i = 1'b0;
    #1 check_zero("async_rst");
    #3 rst_i = 1'b1;
    set_op(1'b1, 3'b010, 32'd20, 32'd22, 32'd0, 1'b0, 2'b00, 2'b00,
           32'd0, 32'd0, 2'b10, 2'b00, 5'd7);
    run_single("add_after_rst");

    // MUL with immediate, then a back-to-back forwarded MUL.
    set_op(1'b1, 3'b011, 32'd7, 32'd0, 32'hFFFF_FFFD, 1'b1, 2'b00, 2'b00,
           32'd0, 32'd0, 2'b10, 2'b00, 5'd3);
    run_mul("mul_imm", 1'b0);
    check("mul_imm_const", EXMEM_ALUResult_o, 32'hFFFF_FFEB);
    set_op(1'b1, 3'b011, 32'd0, 32'd4, 32'd0, 1'b0, 2'b10, 2'b00,
           32'd6, 32'd0, 2'b10, 2'b00, 5'd5);
    run_mul("mul_fwd", 1'b1);
    check("mul_fwd_const", EXMEM_ALUResult_o, 32'd24);

    // Reset at BUSY cycle 10, then the MUL is presented again.
    set_op(1'b1, 3'b011, 32'd123, 32'd456, 32'd0, 1'b0, 2'b00, 2'b00,
           32'd0, 32'd0, 2'b10, 2'b10, 5'd11);
    step();
    repeat (9) step();
    check("busy10_stall", 32'(stall_o), 32'd1);
    #2 rst_i = 1'b0; valid_i = 1'b0;
    #1 check_zero("busy_rst");
    check("busy_rst_state", 32'(dbg_state_o), 32'd0);
    #3 rst_i = 1'b1; valid_i = 1'b1;
    run_mul("mul_after_rst", 1'b0);
    check("mul_after_rst_const", EXMEM_ALUResult_o, 32'd56088);

    // Randomized mix of ops, bubbles and multiplies.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] ctrl;
      logic       v;
      if ($urandom_range(0, 5) == 0) ctrl = 3'b011;
      else begin
        case ($urandom_range(0, 6))
          0: ctrl = 3'b000; 1: ctrl = 3'b001; 2: ctrl = 3'b010;
          3: ctrl = 3'b110; 4: ctrl = 3'b111; 5: ctrl = 3'b100;
          default: ctrl = 3'b101;
        endcase
      end
      v = ($urandom_range(0, 9) != 0);
      set_op(v, ctrl, pick_val(), pick_val(), pick_val(), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick_val(), pick_val(),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      if (v && ctrl == 3'b011) run_mul($sformatf("rnd%0d_mul", i), 1'($urandom_range(0, 1)));
      else run_single($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting directly downstream of the forwarding unit and the ID/EX register. It applies the forwarding selects to choose operands, runs a single-cycle ALU or a 32-cycle iterative multiplier, and owns the EX/MEM pipeline register. While a multiply is in flight it stalls the upstream stages and injects bubbles into MEM.

## Interface
- No parameters; datapath fixed at 32 bits, register address 5 bits.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- valid_i  input  1  ID/EX holds a real instruction.
- RsData_i, RtData_i  input  32  register-file operands from ID/EX.
- Imm_i  input  32  sign-extended immediate from ID/EX.
- ALUSrc_i  input  1  1 = operand B is Imm_i.
- ALUCtrl_i  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 MUL; other codes are treated as ADD.
- WB_i  input  2  WB control; bit 1 is RegWrite.
- M_i  input  2  MEM control (MemRead, MemWrite).
- WriteAddr_i  input  5  destination register.
- mux6_i, mux7_i  input  2  forward selects for Rs/Rt: 00 register, 10 EXMEM_Data_i, 01 MEMWB_Data_i, 11 treated as 00.
- EXMEM_Data_i  input  32  EX/MEM ALU result for forwarding.
- MEMWB_Data_i  input  32  MEM/WB write-back data for forwarding.
- stall_o  output  1  hold PC, IF/ID and ID/EX this cycle.
- EXMEM_WB_o  output  2  registered WB control.
- EXMEM_M_o  output  2  registered MEM control.
- EXMEM_ALUResult_o  output  32  registered result.
- EXMEM_RtData_o  output  32  registered forwarded Rt, used as store data.
- EXMEM_WriteAddr_o  output  5  registered destination.

## Operation
- Operand A is the forwarded Rs value.
- Forwarded Rt is the value selected by mux7_i. Operand B is Imm_i when ALUSrc_i=1, otherwise forwarded Rt.
- ADD and SUB wrap modulo 2^32 with no overflow flag. SLT compares signed and produces 32'd1 or 32'd0.
- MUL produces the low 32 bits of the product; this is identical for signed and unsigned operands.
- Multiplier state machine has three states:
  - IDLE: if valid_i and ALUCtrl_i=MUL, latch operand A and operand B into internal registers, clear the 5-bit counter, and go to BUSY. Otherwise perform a single-cycle op.
  - BUSY: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment the counter. After the 32nd BUSY cycle (counter = 31) go to DONE.
  - DONE: unconditionally return to IDLE. The MUL held in ID/EX is not re-triggered in this state.
- stall_o is combinational: 1 in BUSY, and 1 in IDLE when valid_i and ALUCtrl_i=MUL. It is 0 otherwise, including in DONE.
- EX/MEM register update, on each clock edge:
  - IDLE with a single-cycle op: load the ALU result, forwarded Rt, WriteAddr_i, WB_i and M_i.
  - IDLE with a MUL issue, and all of BUSY: load a bubble (WB=00, M=00, data/address zero).
  - DONE: load the accumulator as the result, plus forwarded Rt, WriteAddr_i, WB_i and M_i from the still-held ID/EX.
  - valid_i=0 in IDLE: load a bubble.
- Latched MUL operands are immune to forwarding-source changes while the downstream pipeline drains during BUSY.

## Timing
- Reset (rst_i low), applied asynchronously, including mid-multiply:
  - state → IDLE, counter and accumulator → 0.
  - All EXMEM_* outputs → 0.
  - stall_o → 0, unless valid_i and ALUCtrl_i=MUL are already present in IDLE.
- Single-cycle ops have 1-cycle latency: inputs in cycle N appear on EXMEM_* after edge N.
- MUL timeline:
  - Issue cycle N: stall_o=1.
  - BUSY cycles N+1..N+32: stall_o=1.
  - DONE cycle N+33: stall_o=0.
  - The result appears on EXMEM_* after edge N+33, and upstream advances on that same edge.
- Back-to-back MULs: the second one issues from IDLE in cycle N+34, with no extra gap.
- Forwarding selects and data are sampled only in IDLE and DONE cycles; for a MUL they are sampled at issue.

## Test plan
- Drive rst_i low in the middle of a run → all EXMEM_* outputs 0 and stall_o 0 immediately, without waiting for a clock edge. After release, an ADD completes normally.
- ADD with mux6_i=10, EXMEM_Data_i=5, RtData_i=3, mux7_i=00 → EXMEM_ALUResult_o=8 and WB/M/WriteAddr passed through, after one edge.
- SLT with RsData_i=FFFFFFFF, mux7_i=01, MEMWB_Data_i=1 → result 1. SUB with the same operands → FFFFFFFE.
- MUL with Rs=7 and ALUSrc_i=1, Imm_i=FFFFFFFD → stall_o high for exactly 33 cycles and EXMEM_WB_o=00 throughout. Then EXMEM_ALUResult_o=FFFFFFEB with WB_i copied, and stall_o=0 in the DONE cycle.
- MUL issued with forwarded Rs=6 (mux6_i=10), then EXMEM_Data_i changes to 100 during BUSY; Rt=4 → result 24.
- Reset asserted at BUSY cycle 10 → IDLE with stall_o=0. After reset is released, re-presenting the MUL → full 33-cycle stall again and the correct product.
